count8_down_timer: RTL and testbench

//  Loadable down-counter/timer: the counting-down counterpart of the count8 up-counter family.
//  - Same load/enable interface as the up-counters: a value loaded on CNT_In counts down to zero.
//  - Then raises a one-cycle done pulse and returns to idle.
//  - Used as an interval/timeout source beside the count8 up-counters, on the same clk/res domain.

---
 rtl/count8_down_timer.sv | 95 +++++++++
 tb/tb_count8_down_timer.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/count8_down_timer.sv
// count8_down_timer: loadable down-counter/timer.
// A nonzero load starts a count that runs down to zero while EN=1. The
// final decrement raises a one-cycle done pulse. A load always takes
// priority over counting. A load of zero stops the timer.
// Optional feature macro: COUNT8_AUTO_RELOAD_EN. When it is defined, the
// timer restarts from the last nonzero load value, which produces a
// periodic done.
module count8_down_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             res,
  input  logic             EN,
  input  logic             load,
  input  logic [WIDTH-1:0] CNT_In,
  output logic [WIDTH-1:0] CNT,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state, w_state_nx;
  logic [WIDTH-1:0] r_cnt, w_cnt_nx;
  logic             r_busy, r_done;
  logic             w_ld_nz;
  logic             w_hit;
  logic             w_last;

  assign w_ld_nz = load && (CNT_In != '0);
  assign w_last  = (r_cnt == WIDTH'(1));
  // The final decrement is the only event that produces done. A load in
  // the same cycle cancels it.
  assign w_hit   = !load && (r_state == S_RUN) && EN && w_last;

`ifdef COUNT8_AUTO_RELOAD_EN
  logic [WIDTH-1:0] r_reload;

  // Capture the interval on every nonzero load, for periodic restart.
  always_ff @(posedge clk or negedge res) begin
    if (!res)         r_reload <= '0;
    else if (w_ld_nz) r_reload <= CNT_In;
  end
`endif

  // Next-state logic: load first, then count, then hold.
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    if (load) begin
      w_cnt_nx   = CNT_In;
      w_state_nx = w_ld_nz ? S_RUN : S_IDLE;
    end else begin
      case (r_state)
        S_RUN: begin
          if (EN) begin
            if (w_last) begin
`ifdef COUNT8_AUTO_RELOAD_EN
              w_cnt_nx   = r_reload;
              w_state_nx = S_RUN;
`else
              w_cnt_nx   = '0;
              w_state_nx = S_DONE;
`endif
            end else begin
              w_cnt_nx = r_cnt - WIDTH'(1);
            end
          end
        end
        S_DONE:  w_state_nx = S_IDLE;
        default: ;
      endcase
    end
  end

  // Register the state, the count, and the outputs decoded from the next state.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_busy  <= (w_state_nx == S_RUN);
      r_done  <= w_hit;
    end
  end

  assign CNT  = r_cnt;
  assign busy = r_busy;
  assign done = r_done;

endmodule

// File: tb/tb_count8_down_timer.sv
// Testbench for count8_down_timer. Directed sequences and random traffic
// drive a behavioural timer model. Each expected output is queued at the
// clock edge, and a monitor compares it at the following falling edge.
module tb_count8_down_timer;

`ifdef COUNT8_AUTO_RELOAD_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       res = 1'b0;
  logic       EN = 1'b0;
  logic       load = 1'b0;
  logic [7:0] CNT_In = 8'h00;
  logic [7:0] CNT;
  logic       busy, done;

  typedef struct {
    logic [7:0] cnt;
    logic       busy;
    logic       done;
    int         id;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   n_id = 0;

  int m_cnt = 0;
  bit m_run = 0;
  bit m_done = 0;
  int m_rel = 0;

  count8_down_timer #(.WIDTH(8)) dut (
    .clk(clk), .res(res), .EN(EN), .load(load),
    .CNT_In(CNT_In), .CNT(CNT), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic push_exp();
    exp_t e;
    e.cnt  = m_cnt[7:0];
    e.busy = m_run;
    e.done = m_done;
    e.id   = n_id;
    n_id++;
    exp_q.push_back(e);
  endtask

  task automatic model_edge();
    m_done = 0;
    if (!res) begin
      m_cnt = 0; m_run = 0; m_rel = 0;
    end else if (load) begin
      m_cnt = int'(CNT_In);
      m_run = (CNT_In != 0);
      if (CNT_In != 0) m_rel = int'(CNT_In);
    end else if (m_run && EN) begin
      if (m_cnt == 1) begin
        m_done = 1;
        if (AUTO) m_cnt = m_rel;
        else begin m_cnt = 0; m_run = 0; end
      end else begin
        m_cnt = m_cnt - 1;
      end
    end
  endtask

  task automatic tick(input logic ld, input logic en, input logic [7:0] v);
    load = ld; EN = en; CNT_In = v;
    @(posedge clk);
    model_edge();
    push_exp();
    #1;
  endtask

  task automatic async_rst();
    res = 1'b0;
    m_cnt = 0; m_run = 0; m_done = 0; m_rel = 0;
    if (exp_q.size() > 0) void'(exp_q.pop_back());
    push_exp();
  endtask

  task automatic chk_now(input string tag);
    checks++;
    if (CNT !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL %s: got CNT=%02h busy=%b done=%b, want reset values",
               tag, CNT, busy, done);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if (CNT !== e.cnt || busy !== e.busy || done !== e.done) begin
        failures++;
        $display("FAIL out[%0d]: got CNT=%02h busy=%b done=%b, want CNT=%02h busy=%b done=%b",
                 e.id, CNT, busy, done, e.cnt, e.busy, e.done);
      end
    end
  end

  initial begin
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b1, 8'hFF);
    chk_now("reset-held");
    res = 1'b1;
    tick(1'b0, 1'b0, 8'h00);

    tick(1'b1, 1'b1, 8'h05);
    for (int i = 0; i < 8; i++) tick(1'b0, 1'b1, 8'h00);

    tick(1'b1, 1'b1, 8'h03);
    tick(1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b1, 8'h00);

    tick(1'b1, 1'b1, 8'h04);
    tick(1'b0, 1'b1, 8'h00);
    tick(1'b0, 1'b1, 8'h00);
    tick(1'b1, 1'b1, 8'h11);
    tick(1'b0, 1'b1, 8'h00);
    tick(1'b1, 1'b1, 8'h02);
    tick(1'b0, 1'b1, 8'h00);
    tick(1'b1, 1'b1, 8'h09);
    tick(1'b0, 1'b1, 8'h00);
    tick(1'b1, 1'b1, 8'h00);
    tick(1'b0, 1'b1, 8'h00);

    tick(1'b1, 1'b1, 8'h09);
    tick(1'b0, 1'b1, 8'h00);
    tick(1'b0, 1'b1, 8'h00);
    async_rst();
    #1;
    chk_now("async-reset");
    tick(1'b0, 1'b1, 8'h00);
    res = 1'b1;
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 8'h00);

    tick(1'b1, 1'b1, 8'hFF);
    for (int i = 0; i < 260; i++) tick(1'b0, 1'b1, 8'h00);

    if (AUTO) begin
      tick(1'b1, 1'b1, 8'h03);
      for (int i = 0; i < 10; i++) tick(1'b0, 1'b1, 8'h00);
      tick(1'b1, 1'b1, 8'h00);
      for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 8'h00);
    end

    for (int i = 0; i < 600; i++) begin
      int r;
      logic [7:0] v;
      r = int'($urandom_range(0, 99));
      if (r < 2) begin
        async_rst();
        tick(1'b0, 1'b1, 8'h00);
        res = 1'b1;
      end else begin
        v = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'($urandom_range(0, 6));
        tick(($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0), v);
      end
    end

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL wait expired: %0d expectations never compared", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
